aes_round_seq: RTL
==================

Name: aes_round_seq

Overview:
Iterative AES encryption controller. Sequences one shared one_round core and one final_round core over NR rounds (2 cycles per round) and performs the initial AddRoundKey. Sits between a block-level valid/ready stream and an external round-key store, which it addresses by round index. One block in flight at a time.

Parameters:
NR, 10, total AES rounds (10/12/14 for AES-128/192/256); legal values 10, 12, 14 only
RKW, 4, width of the round-key index; must hold NR

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  plaintext block offered
in_ready  out  1  block accepted when in_valid & in_ready
in_data  in  128  plaintext block, AES byte order (byte 0 at [127:120])
rk_idx  out  RKW  round-key index requested from the key store
rk_data  in  128  round key for rk_idx; combinational read, same cycle
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts when out_valid & out_ready
out_data  out  128  ciphertext block
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: FSM=IDLE, round counter=0, state_reg=0, out_reg=0, in_ready=1, out_valid=0, busy=0, rk_idx=0.
- The round cores have no reset. Their contents after reset are don't-care; the controller never uses them before refilling.
- States: IDLE, RND_A, RND_B, FIN_A, FIN_B, CAPT, DONE.
- IDLE:
  - in_ready=1; rk_idx=0.
  - On accept: state_reg <= in_data ^ rk_data, rnd <= 1, go to RND_A.
- RND_A and RND_B form one middle round rnd (1..NR-1):
  - rk_idx=rnd is held stable through both cycles. one_round applies the key in its second cycle.
  - one_round.state_in = state_reg when rnd==1, otherwise one_round.state_out (feedback).
  - RND_A always goes to RND_B.
  - RND_B: if rnd==NR-1, go to FIN_A; else rnd <= rnd+1 and go to RND_A.
- FIN_A and FIN_B:
  - rk_idx=NR; final_round.state_in = one_round.state_out.
  - FIN_A goes to FIN_B; FIN_B goes to CAPT.
- CAPT: out_reg <= final_round.state_out; go to DONE.
- DONE:
  - out_valid=1; out_data=out_reg, held stable until handshake.
  - On out_ready: out_valid drops, go to IDLE.
  - in_ready stays 0 until IDLE is reached, so there is no same-cycle accept.
- Latency: out_valid rises exactly 2*NR+1 edges after the accept edge (21 for NR=10).
  - Minimum accept-to-accept interval is 2*NR+3 cycles with out_ready held high.
- rk_idx outside the listed states = 0. The key store must return the key for rk_idx in the same cycle.
- Values on in_data/in_valid while busy are ignored. A block held on in_valid is taken on the first IDLE cycle.
- Backpressure: DONE holds indefinitely; out_data must not change while waiting.
- rst asserted mid-operation:
  - Immediate return to reset values and the block is discarded.
  - No out_valid for it, not even a partial one.
- rnd never exceeds NR-1 and never wraps. An illegal NR is a synthesis-time error.

Optional Feature:
AES_SEQ_ABORT_EN
- With the macro: adds input abort (1 bit). abort high in any state other than IDLE/DONE forces IDLE on the next edge.
  - out_valid is not asserted; out_reg is unchanged.
  - abort is ignored in IDLE and DONE.
- Without the macro: no abort port, and the sequence always runs to completion.

Decomposition:
- Shared package aes_pkg holds:
  - the FSM state enum;
  - AES_BLK_W=128;
  - legal NR constants NR_AES128=10, NR_AES192=12, NR_AES256=14.
- Datapath reuses the existing one_round and final_round cores as instances; no new datapath logic.
- One natural sub-module: aes_seq_fsm (state register, round counter, rk_idx, handshake outputs). The top holds state_reg, out_reg and the state_in muxes.

Test Plan:
- Reset, then FIPS-197 App. C.1:
  - stimulus: key 000102030405060708090a0b0c0d0e0f (bench key store), pt 00112233445566778899aabbccddeeff;
  - required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 21 edges after accept.
- FIPS-197 App. B:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734;
  - required: out_data 3925841d02dc09fbdc118597196a0b32.
- Backpressure:
  - stimulus: out_ready=0 for 50 cycles, in_valid held high with a second block;
  - required: out_data stable, in_ready=0 throughout; second block accepted on the first IDLE cycle after out_ready.
- rk_idx trace:
  - required sequence: 0 at accept, each 1..9 held for 2 cycles, 10 for 2 cycles.
  - Corrupting rk_data only when rk_idx=5 must change the ciphertext.
- rst asserted at cycle 7 of a block:
  - required: busy=0, out_valid=0, in_ready=1 immediately.
  - The next C.1 block then yields the correct ciphertext.
- With AES_SEQ_ABORT_EN:
  - stimulus: abort at cycle 12;
  - required: IDLE next edge, no out_valid, prior out_reg retained.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level round helpers used by the
// iterative round sequencer and its round cores.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  typedef enum logic [2:0] {
    IDLE,
    RND_A,
    RND_B,
    FIN_A,
    FIN_B,
    CAPT,
    DONE
  } seq_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte 4*c+r is row r of column c; byte 0 sits at [127:120].
  function automatic logic [AES_BLK_W-1:0] sub_shift(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [AES_BLK_W-1:0] mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_seq_fsm.sv
// Round sequencer FSM: state, round counter, key index and stream handshakes.
// Optional AES_SEQ_ABORT_EN adds an abort input that drops an in-flight block.
module aes_seq_fsm
  import aes_pkg::*;
#(
  parameter int unsigned NR  = NR_AES128,
  parameter int unsigned RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           out_ready,
`ifdef AES_SEQ_ABORT_EN
  input  logic           abort,
`endif
  output logic           in_ready,
  output logic           out_valid,
  output logic           busy,
  output logic [RKW-1:0] rk_idx,
  output logic           accept_c,
  output logic           first_rnd_c,
  output logic           capt_c
);

  if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
    $error("aes_seq_fsm: NR must be 10, 12 or 14");
  end
  if (NR >= (2 ** RKW)) begin : g_bad_rkw
    $error("aes_seq_fsm: RKW too narrow for NR");
  end

  seq_state_e     state_d, state_q;
  logic [RKW-1:0] rnd_d, rnd_q, rk_idx_d, rk_idx_q;
  logic           in_ready_d, in_ready_q, out_valid_d, out_valid_q, busy_d, busy_q;
  logic           abort_hit;

`ifdef AES_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE) && (state_q != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    accept_c    = (state_q == IDLE) && in_valid;
    first_rnd_c = (rnd_q == RKW'(1));
    capt_c      = (state_q == CAPT) && !abort_hit;
    case (state_q)
      IDLE:  if (in_valid) begin
               state_d = RND_A;
               rnd_d   = RKW'(1);
             end
      RND_A: state_d = RND_B;
      RND_B: if (rnd_q == RKW'(NR - 1)) state_d = FIN_A;
             else begin
               rnd_d   = rnd_q + RKW'(1);
               state_d = RND_A;
             end
      FIN_A: state_d = FIN_B;
      FIN_B: state_d = CAPT;
      CAPT:  state_d = DONE;
      DONE:  if (out_ready) begin
               state_d = IDLE;
               rnd_d   = '0;
             end
      default: begin
        state_d = IDLE;
        rnd_d   = '0;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      rnd_d   = '0;
    end
    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    case (state_d)
      RND_A, RND_B: rk_idx_d = rnd_d;
      FIN_A, FIN_B: rk_idx_d = RKW'(NR);
      default:      rk_idx_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      rk_idx_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      rk_idx_q    <= rk_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;

endmodule

// File: rtl/final_round.sv
// Two-cycle AES final round: SubBytes/ShiftRows, then AddRoundKey.
module final_round
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [AES_BLK_W-1:0] mid_d, mid_q, out_d, out_q;

  always_comb begin
    mid_d = sub_shift(state_in);
    out_d = mid_q ^ round_key;
  end

  always_ff @(posedge clk) begin
    mid_q <= mid_d;
    out_q <= out_d;
  end

  assign state_out = out_q;

endmodule

// File: rtl/one_round.sv
// Two-cycle AES middle round: SubBytes/ShiftRows/MixColumns, then AddRoundKey.
module one_round
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic [AES_BLK_W-1:0] state_in,
  input  logic [AES_BLK_W-1:0] round_key,
  output logic [AES_BLK_W-1:0] state_out
);

  logic [AES_BLK_W-1:0] mid_d, mid_q, out_d, out_q;

  always_comb begin
    mid_d = mix_columns(sub_shift(state_in));
    out_d = mid_q ^ round_key;
  end

  // No reset: every stage is refilled before the sequencer samples it.
  always_ff @(posedge clk) begin
    mid_q <= mid_d;
    out_q <= out_d;
  end

  assign state_out = out_q;

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES encryption controller around shared one_round/final_round cores.
// Optional AES_SEQ_ABORT_EN adds an abort input that drops an in-flight block.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR  = NR_AES128,
  parameter int unsigned RKW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic [RKW-1:0]       rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
`ifdef AES_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy
);

  logic                 accept_c, first_rnd_c, capt_c;
  logic [AES_BLK_W-1:0] state_reg_d, state_reg_q, out_reg_d, out_reg_q;
  logic [AES_BLK_W-1:0] rnd_in, rnd_out, fin_out;

  aes_seq_fsm #(.NR(NR), .RKW(RKW)) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
`ifdef AES_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .busy        (busy),
    .rk_idx      (rk_idx),
    .accept_c    (accept_c),
    .first_rnd_c (first_rnd_c),
    .capt_c      (capt_c)
  );

  // Round 1 starts from the whitened input; later rounds feed back the core output.
  always_comb begin
    state_reg_d = accept_c ? (in_data ^ rk_data) : state_reg_q;
    out_reg_d   = capt_c ? fin_out : out_reg_q;
    rnd_in      = first_rnd_c ? state_reg_q : rnd_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg_q <= '0;
      out_reg_q   <= '0;
    end else begin
      state_reg_q <= state_reg_d;
      out_reg_q   <= out_reg_d;
    end
  end

  one_round u_one_round (
    .clk       (clk),
    .state_in  (rnd_in),
    .round_key (rk_data),
    .state_out (rnd_out)
  );

  final_round u_final_round (
    .clk       (clk),
    .state_in  (rnd_out),
    .round_key (rk_data),
    .state_out (fin_out)
  );

  assign out_data = out_reg_q;

endmodule
